// File: rtl/cur_block_buffer_if.sv
// Write channel of the current-block ping-pong buffer.
// Valid/ready handshake carrying one packed pixel word.
interface cur_block_buffer_if #(
  parameter int PIX_W  = 8,
  parameter int IN_PIX = 4
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [IN_PIX*PIX_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/cur_block_buffer.sv
// Ping-pong buffer for current-frame blocks feeding the PE array.
// One bank fills in raster order while the other drives blk_out.
module cur_block_buffer #(
  parameter int BLK     = 8,
  parameter int PIX_W   = 8,
  parameter int IN_PIX  = 4,
  parameter int STAGGER = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  cur_block_buffer_if.slave                   wr,
  input  logic                                next_block,
  output logic                                swap_err,
  output logic                                wr_full,
  output logic                                blk_valid,
  output logic [BLK*BLK*PIX_W-1:0]            blk_out,
  output logic                                xfer,
  output logic [((BLK>2)?$clog2(BLK):1)-1:0] xfer_row
);

  localparam int XW      = (BLK > 2) ? $clog2(BLK) : 1;
  localparam int NPIX    = BLK * BLK;
  localparam int ROW_W   = BLK * PIX_W;
  localparam int WORD_W  = IN_PIX * PIX_W;
  localparam int BANK_W  = NPIX * PIX_W;
  localparam int WPW     = (NPIX > 2) ? $clog2(NPIX) : 1;
  localparam int LAST_WP = NPIX - IN_PIX;

  typedef enum logic {
    ST_LOAD,
    ST_XFER
  } state_t;

  state_t           state_q, state_d;
  logic             rd_sel_q, rd_sel_d;
  logic [WPW-1:0]   wp_q, wp_d;
  logic             wr_full_q, wr_full_d;
  logic             blk_valid_q, blk_valid_d;
  logic [XW-1:0]    xfer_row_q, xfer_row_d;
  logic             swap_err_q, swap_err_d;

  logic [1:0][BANK_W-1:0] bank_q, bank_d;

  logic wr_ready_int;
  logic wr_en;
  logic swap_ok;
  logic wr_bank;

  assign wr_ready_int = !wr_full_q && (state_q == ST_LOAD);
  assign wr_en        = wr.wr_valid && wr_ready_int;
  assign swap_ok      = next_block && wr_full_q
                        && (state_q == ST_LOAD);
  assign wr_bank      = ~rd_sel_q;

  assign wr.wr_ready = wr_ready_int;
  assign wr_full     = wr_full_q;
  assign blk_valid   = blk_valid_q;
  assign xfer        = (state_q == ST_XFER);
  assign xfer_row    = xfer_row_q;
  assign swap_err    = swap_err_q;

  // Fill pointer, bank swap and staggered handover sequencing.
  always_comb begin
    state_d     = state_q;
    rd_sel_d    = rd_sel_q;
    wp_d        = wp_q;
    wr_full_d   = wr_full_q;
    blk_valid_d = blk_valid_q;
    xfer_row_d  = xfer_row_q;
    swap_err_d  = next_block && !swap_ok;
    unique case (state_q)
      ST_LOAD: begin
        if (wr_en) begin
          if (wp_q == WPW'(LAST_WP)) begin
            wr_full_d = 1'b1;
          end else begin
            wp_d = wp_q + WPW'(IN_PIX);
          end
        end
        if (swap_ok) begin
          rd_sel_d    = ~rd_sel_q;
          wp_d        = '0;
          wr_full_d   = 1'b0;
          blk_valid_d = 1'b1;
          if (STAGGER != 0) begin
            state_d    = ST_XFER;
            xfer_row_d = '0;
          end
        end
      end
      ST_XFER: begin
        if (xfer_row_q == XW'(BLK - 1)) begin
          state_d    = ST_LOAD;
          xfer_row_d = '0;
        end else begin
          xfer_row_d = xfer_row_q + XW'(1);
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      rd_sel_q    <= 1'b0;
      wp_q        <= '0;
      wr_full_q   <= 1'b0;
      blk_valid_q <= 1'b0;
      xfer_row_q  <= '0;
      swap_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_sel_q    <= rd_sel_d;
      wp_q        <= wp_d;
      wr_full_q   <= wr_full_d;
      blk_valid_q <= blk_valid_d;
      xfer_row_q  <= xfer_row_d;
      swap_err_q  <= swap_err_d;
    end
  end

  // Place an accepted word into the write bank.
  always_comb begin
    bank_d = bank_q;
    if (wr_en) begin
      bank_d[wr_bank][int'(wp_q)*PIX_W +: WORD_W] = wr.wr_data;
    end
  end

  // Pixel storage carries no reset.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  // Rows up to the wavefront come from the new bank, the rest from the old.
  always_comb begin
    blk_out = '0;
    if (blk_valid_q) begin
      for (int r = 0; r < BLK; r++) begin
        if ((state_q == ST_XFER) && (XW'(r) > xfer_row_q)) begin
          blk_out[r*ROW_W +: ROW_W] = bank_q[~rd_sel_q][r*ROW_W +: ROW_W];
        end else begin
          blk_out[r*ROW_W +: ROW_W] = bank_q[rd_sel_q][r*ROW_W +: ROW_W];
        end
      end
    end
  end

endmodule

// File: doc/cur_block_buffer.md
# cur_block_buffer

- Parametrised ping-pong buffer for current-frame blocks in the motion-estimation datapath.
- Accepts packed pixel words in raster order into one bank while the other bank drives a full BLK×BLK block to the PE array.
- On a block swap, the new block is handed over either at once or row-staggered, one row per cycle, to match the systolic PE wavefront.
- Adds write handshaking, fill tracking and swap-error reporting.

## Interface

Parameters:
- BLK, 8, block edge in pixels (rows = columns = BLK); BLK ≥ 2
- PIX_W, 8, bits per pixel
- IN_PIX, 4, pixels per write word; BLK*BLK must be a multiple of IN_PIX
- STAGGER, 1, 1 = row-staggered handover, 0 = instantaneous handover

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- wr_valid  in  1  wr_data is valid
- wr_ready  out  1  buffer can accept a write word
- wr_data  in  IN_PIX*PIX_W  pixel word; lowest pixel at the LSBs
- next_block  in  1  request to swap banks
- swap_err  out  1  one-cycle pulse when next_block is rejected
- wr_full  out  1  write bank holds a complete block
- blk_valid  out  1  blk_out holds a valid block
- blk_out  out  BLK*BLK*PIX_W  block; row r, column c at pixel index r*BLK+c, row 0 at the LSBs
- xfer  out  1  row-staggered handover in progress
- xfer_row  out  max(1,$clog2(BLK))  handover step t while xfer=1, else 0

## Operation

- **Storage:** two banks of BLK*BLK pixels. A read-bank select register `rd_sel` picks the read bank; the other bank is the write bank. Storage is not reset.
- **Write:**
  - A word is accepted on a clock edge where wr_valid && wr_ready.
  - It goes to pixels [wp, wp+IN_PIX) of the write bank, and wp advances by IN_PIX.
  - wr_full sets on the edge that accepts the last word, at wp = BLK*BLK − IN_PIX. wp then holds.
  - wr_ready = !wr_full && !xfer.
- **Swap:**
  - next_block is accepted only when wr_full=1 and xfer=0.
  - On acceptance: rd_sel toggles, wp=0, wr_full=0, blk_valid=1 (sticky until reset).
  - If STAGGER=1, xfer=1 and xfer_row=0 are also set on acceptance.
  - A rejected next_block (wr_full=0 or xfer=1) changes no state and pulses swap_err on the next cycle.
- **Handover (STAGGER=1):**
  - While xfer=1 with step t, rows 0..t of blk_out come from the new read bank.
  - Rows t+1..BLK−1 come from the old bank, which is now the write bank. Writes are blocked during xfer, so those rows stay intact.
  - xfer_row increments each cycle. When xfer_row = BLK−1, the next edge clears xfer and xfer_row.
- **Handover (STAGGER=0):** all rows switch on the accepting edge; xfer stays 0.
- **Output:** blk_out is 0 while blk_valid=0. Otherwise it is a function of registered state only, with no combinational path from any input.

## Timing

- **Reset values:** wr_ready=1, wr_full=0, blk_valid=0, blk_out=0, xfer=0, xfer_row=0, swap_err=0; rd_sel=0, wp=0.
- **Write latency:** the word accepted at edge k is in storage after edge k.
  - With N = BLK*BLK/IN_PIX, wr_full=1 after the N-th accepting edge.
  - Back-to-back fill takes N cycles.
- **Swap accepted at edge k, STAGGER=1:**
  - In cycle k+1+t (t=0..BLK−1): xfer=1, xfer_row=t, rows 0..t are new.
  - In cycle k+1+BLK: xfer=0, wr_ready=1, all rows are new.
- **Swap accepted at edge k, STAGGER=0:** the full new block and wr_ready=1 appear in cycle k+1.
- **Last-word edge coinciding with next_block:** the request is rejected because wr_full was still 0; swap_err=1 in the following cycle.
- **Reset asserted mid-handover or mid-fill:** all outputs go immediately to their reset values. The partial block is discarded.

## Test plan

- **Post-reset fill:** BLK=8, IN_PIX=4, STAGGER=1. Write 16 words with pixel value = index, then next_block. Require:
  - wr_full=1 after the 16th word;
  - 8 cycles of xfer with xfer_row 0..7;
  - blk_out pixel i = i after handover.
- **Staggered wavefront:** old block all 0x11, new block all 0x22, swap. Require:
  - at xfer_row=3, rows 0–3 = 0x22 and rows 4–7 = 0x11;
  - wr_ready=0 throughout xfer.
- **Rejected swaps:** next_block at wp=8 → swap_err pulse and no state change; next_block during xfer → swap_err pulse and xfer_row continues.
- **Write stall:** wr_valid held high with wr_full=1 → no further writes. Then swap → the first new word lands at pixel 0 of the other bank.
- **STAGGER=0, BLK=4, IN_PIX=2:** fill 8 words and swap → the complete block appears in cycle k+1 with xfer=0. Then assert rst mid-fill of the next block → all outputs return to their reset values.
